// File: rtl/fifo_wr_arb_pkg.sv
// Shared FIFO subsystem definitions: data width, default requester count,
// the write arbiter's state encoding and a round-robin index helper.
package pack_FIFO;

  localparam int unsigned FIFO_WIDTH  = 8;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ACK_CNT_W   = 16;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Wrap an index that is known to be below 2*n back into 0..n-1.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    if (idx >= n) begin
      return idx - n;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Bundle between the producers / FIFO write port and the write arbiter.
//   master : arbiter side (drives req_ready, FIFO write strobe/data, status)
//   slave  : environment side (producers and FIFO flags)
interface fifo_wr_arb_if #(
  parameter int unsigned NUM_REQ    = pack_FIFO::NUM_REQ_DEF,
  parameter int unsigned FIFO_WIDTH = pack_FIFO::FIFO_WIDTH
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned ACK_W = pack_FIFO::ACK_CNT_W;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;

  logic                  fifo_full;
  logic                  fifo_almostfull;
  logic                  fifo_wr_ack;
  logic                  fifo_overflow;
  logic                  fifo_wr_en;
  logic [FIFO_WIDTH-1:0] fifo_data_in;

  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic [ACK_W-1:0] ack_cnt;
  logic             err_overflow;

  modport master (
    input  req_valid, req_last, req_data,
    input  fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in,
    output grant_id, busy, ack_cnt, err_overflow
  );

  modport slave (
    output req_valid, req_last, req_data,
    output fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in,
    input  grant_id, busy, ack_cnt, err_overflow
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or after
// i_rr_ptr, wrapping modulo NUM_REQ.
//   i_req    : request vector
//   i_rr_ptr : highest-priority index this cycle
//   o_found  : any request set
//   o_sel    : chosen index (0 when nothing found)
module rr_pick
  import pack_FIFO::*;
#(
  parameter  int unsigned NUM_REQ = pack_FIFO::NUM_REQ_DEF,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_sel
);

  int unsigned w_idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    o_found = 1'b0;
    o_sel   = '0;
    w_idx   = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      w_idx = rr_wrap(32'(i_rr_ptr) + 32'(i), NUM_REQ);
      if (i_req[ID_W'(w_idx)]) begin
        o_found = 1'b1;
        o_sel   = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of the FIFO write port, with packet
// lock so multi-word packets land contiguously and self-throttling on the
// FIFO full / almost-full flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : producer handshakes, FIFO write port and status (master side)
module fifo_wr_arb
#(
  parameter int unsigned NUM_REQ    = pack_FIFO::NUM_REQ_DEF,
  parameter int unsigned FIFO_WIDTH = pack_FIFO::FIFO_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  fifo_wr_arb_if.master bus
);
  import pack_FIFO::*;

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned ACK_W = ACK_CNT_W;

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic                  r_wr_en;
  logic [FIFO_WIDTH-1:0] r_data;
  logic [ACK_W-1:0]      r_ack_cnt;
  logic                  r_err_ovf;

  logic                  w_found;
  logic [ID_W-1:0]       w_sel;
  logic                  w_space_ok;
  logic                  w_accept;
  logic                  w_done;
  logic [ID_W-1:0]       w_grant;
  logic [NUM_REQ-1:0]    w_ready;
  logic [ID_W-1:0]       w_ptr_nxt;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (bus.req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_sel    (w_sel)
  );

  // A write already in the output register consumes the last free slot.
  assign w_space_ok = !bus.fifo_full && !(r_wr_en && bus.fifo_almostfull);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grant and ready decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = r_grant_id;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_grant = w_sel;
        end
        if (w_found && w_space_ok && !rst) begin
          w_ready[w_sel] = 1'b1;
          w_accept       = 1'b1;
          w_done         = bus.req_last[w_sel];
          if (!bus.req_last[w_sel]) begin
            w_state_nxt = ARB_LOCKED;
          end
        end
      end
      ARB_LOCKED: begin
        // Ready is offered to the owner even while it has no word.
        if (w_space_ok && !rst) begin
          w_ready[r_grant_id] = 1'b1;
          w_accept            = bus.req_valid[r_grant_id];
          w_done              = w_accept && bus.req_last[r_grant_id];
          if (w_done) begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
    if (rst) begin
      w_grant = '0;
    end
  end

  assign w_ptr_nxt = (32'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + ID_W'(1);

  // Output register, round-robin pointer, ack counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_ack_cnt  <= '0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_data     <= bus.req_data[w_grant];
        r_grant_id <= w_grant;
      end
      if (w_done) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      if (bus.fifo_wr_ack) begin
        r_ack_cnt <= r_ack_cnt + ACK_W'(1);
      end
      if (bus.fifo_overflow) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.grant_id     = w_grant;
  assign bus.busy         = (r_state == ARB_LOCKED);
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_data_in = r_data;
  assign bus.ack_cnt      = r_ack_cnt;
  assign bus.err_overflow = r_err_ovf;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a depth-8 FIFO flag model.
module tb_fifo_wr_arb;

  localparam int unsigned NR    = 4;
  localparam int unsigned W     = 8;
  localparam int          DEPTH = 8;

  logic clk;
  logic rst;
  logic rd_en;
  logic ovf_inj;
  int   n_cmp;
  int   n_bad;
  int   n_model_ovf;
  int   n_wr;

  fifo_wr_arb_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arb #(.NUM_REQ(NR), .FIFO_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO occupancy model: write sampled from the registered strobe.
  int   cnt;
  logic ack_q;
  logic ovf_q;
  logic m_wr;
  logic m_rd;
  assign m_wr = bus.fifo_wr_en && (cnt < DEPTH);
  assign m_rd = rd_en && (cnt > 0);
  always @(posedge clk) begin
    if (rst) begin
      cnt   <= 0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt   <= cnt + (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
      ack_q <= m_wr;
      ovf_q <= bus.fifo_wr_en && bus.fifo_full;
      if (ovf_q) n_model_ovf <= n_model_ovf + 1;
    end
  end
  assign bus.fifo_full       = (cnt == DEPTH);
  assign bus.fifo_almostfull = (cnt == DEPTH - 1);
  assign bus.fifo_wr_ack     = ack_q;
  assign bus.fifo_overflow   = ovf_q | ovf_inj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    rd_en = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; n_model_ovf = 0; n_wr = 0;
    rst = 1'b1; rd_en = 1'b0; ovf_inj = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_last  = '0;
    bus.req_data  = '0;

    // Reset values, with every requester valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(bus.req_ready),    32'h0);
    chk("rst_grant",  32'(bus.grant_id),     32'h0);
    chk("rst_wr_en",  32'(bus.fifo_wr_en),   32'h0);
    chk("rst_data",   32'(bus.fifo_data_in), 32'h0);
    chk("rst_busy",   32'(bus.busy),         32'h0);
    chk("rst_ack",    32'(bus.ack_cnt),      32'h0);
    chk("rst_err",    32'(bus.err_overflow), 32'h0);

    // Fair rotation: single-word packets from all four requesters.
    for (int i = 0; i < int'(NR); i++) bus.req_data[i] = 8'(32'hA0 + i);
    bus.req_last = 4'hF;
    next_cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rot_grant", 32'(bus.grant_id),  32'(k % 4));
      chk("rot_ready", 32'(bus.req_ready), 32'(1) << (k % 4));
      if (k > 0) chk("rot_data", 32'(bus.fifo_data_in), 32'hA0 + 32'((k - 1) % 4));
      next_cyc();
    end
    bus.req_valid = '0;
    @(negedge clk);
    chk("rot_last_data", 32'(bus.fifo_data_in), 32'hA0);
    chk("rot_last_wr",   32'(bus.fifo_wr_en),   32'h1);
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("rot_ack_cnt", 32'(bus.ack_cnt), 32'd5);

    // Packet lock: req0 three-word packet while req1 waits.
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_last  = 4'b0010;
    bus.req_data[0] = 8'h50;
    bus.req_data[1] = 8'h61;
    @(negedge clk);
    chk("lock_c0_ready", 32'(bus.req_ready), 32'b0001);
    chk("lock_c0_busy",  32'(bus.busy),      32'h0);
    next_cyc();
    bus.req_data[0] = 8'h51;
    @(negedge clk);
    chk("lock_c1_busy",  32'(bus.busy),         32'h1);
    chk("lock_c1_ready", 32'(bus.req_ready),    32'b0001);
    chk("lock_c1_data",  32'(bus.fifo_data_in), 32'h50);
    next_cyc();
    bus.req_data[0] = 8'h52;
    bus.req_last    = 4'b0011;
    @(negedge clk);
    chk("lock_c2_grant", 32'(bus.grant_id),     32'h0);
    chk("lock_c2_data",  32'(bus.fifo_data_in), 32'h51);
    next_cyc();
    bus.req_data[0] = 8'h53;
    @(negedge clk);
    chk("lock_c3_busy",  32'(bus.busy),         32'h0);
    chk("lock_c3_grant", 32'(bus.grant_id),     32'h1);
    chk("lock_c3_ready", 32'(bus.req_ready),    32'b0010);
    chk("lock_c3_data",  32'(bus.fifo_data_in), 32'h52);
    next_cyc();
    @(negedge clk);
    chk("lock_c4_grant", 32'(bus.grant_id),     32'h0);
    chk("lock_c4_data",  32'(bus.fifo_data_in), 32'h61);
    next_cyc();
    bus.req_valid = '0;

    // Full throttle: depth 8, no reads, everyone valid.
    do_reset();
    for (int i = 0; i < int'(NR); i++) bus.req_data[i] = 8'(32'hA0 + i);
    bus.req_valid = 4'hF;
    bus.req_last  = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("thr_ready", 32'(bus.req_ready), (k < 8) ? (32'(1) << (k % 4)) : 32'h0);
      if (k < 8) chk("thr_grant", 32'(bus.grant_id), 32'(k % 4));
      if (bus.fifo_wr_en) n_wr++;
      next_cyc();
    end
    chk("thr_writes",    32'(n_wr),             32'd8);
    chk("thr_model_ovf", 32'(n_model_ovf),      32'd0);
    chk("thr_err",       32'(bus.err_overflow), 32'h0);

    // Almost-full corner: one read re-enables exactly one acceptance.
    rd_en = 1'b1;
    @(negedge clk);
    chk("af_full_ready", 32'(bus.req_ready), 32'h0);
    next_cyc();
    rd_en = 1'b0;
    @(negedge clk);
    chk("af_reopen_ready", 32'(bus.req_ready), 32'b0001);
    chk("af_reopen_grant", 32'(bus.grant_id),  32'h0);
    next_cyc();
    @(negedge clk);
    chk("af_pend_ready", 32'(bus.req_ready),    32'h0);
    chk("af_pend_wr",    32'(bus.fifo_wr_en),   32'h1);
    chk("af_pend_data",  32'(bus.fifo_data_in), 32'hA0);
    next_cyc();
    @(negedge clk);
    chk("af_full2_ready", 32'(bus.req_ready), 32'h0);

    // Sticky overflow error.
    ovf_inj = 1'b1;
    next_cyc();
    ovf_inj = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(bus.err_overflow), 32'h1);
    next_cyc();
    @(negedge clk);
    chk("ovf_sticky", 32'(bus.err_overflow), 32'h1);

    // Reset in the middle of a locked req2 packet.
    do_reset();
    bus.req_valid   = 4'b0100;
    bus.req_last    = 4'b0000;
    bus.req_data[2] = 8'hC0;
    @(negedge clk);
    chk("rmp_c0_grant", 32'(bus.grant_id), 32'h2);
    next_cyc();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    @(negedge clk);
    chk("rmp_rst_ready", 32'(bus.req_ready),    32'h0);
    chk("rmp_rst_busy",  32'(bus.busy),         32'h1);
    chk("rmp_rst_wr",    32'(bus.fifo_wr_en),   32'h1);
    chk("rmp_rst_data",  32'(bus.fifo_data_in), 32'hC0);
    next_cyc();
    rst = 1'b0;
    bus.req_last = 4'hF;
    @(negedge clk);
    chk("rmp_busy",  32'(bus.busy),         32'h0);
    chk("rmp_wr",    32'(bus.fifo_wr_en),   32'h0);
    chk("rmp_data",  32'(bus.fifo_data_in), 32'h0);
    chk("rmp_ack",   32'(bus.ack_cnt),      32'h0);
    chk("rmp_err",   32'(bus.err_overflow), 32'h0);
    chk("rmp_grant", 32'(bus.grant_id),     32'h0);
    chk("rmp_ready", 32'(bus.req_ready),    32'b0001);

    // Valid gap while req1 holds the lock; req3 must keep waiting.
    do_reset();
    bus.req_data[1] = 8'h71;
    bus.req_data[3] = 8'h73;
    bus.req_valid   = 4'b1010;
    bus.req_last    = 4'b1000;
    @(negedge clk);
    chk("gap_c0_grant", 32'(bus.grant_id), 32'h1);
    next_cyc();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("gap_c1_ready", 32'(bus.req_ready),    32'b0010);
    chk("gap_c1_data",  32'(bus.fifo_data_in), 32'h71);
    next_cyc();
    @(negedge clk);
    chk("gap_c2_wr",    32'(bus.fifo_wr_en), 32'h0);
    chk("gap_c2_ready", 32'(bus.req_ready),  32'b0010);
    next_cyc();
    bus.req_valid   = 4'b1010;
    bus.req_last    = 4'b1010;
    bus.req_data[1] = 8'h72;
    @(negedge clk);
    chk("gap_c3_wr",    32'(bus.fifo_wr_en), 32'h0);
    chk("gap_c3_busy",  32'(bus.busy),       32'h1);
    chk("gap_c3_grant", 32'(bus.grant_id),   32'h1);
    next_cyc();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("gap_c4_busy",  32'(bus.busy),         32'h0);
    chk("gap_c4_data",  32'(bus.fifo_data_in), 32'h72);
    chk("gap_c4_grant", 32'(bus.grant_id),     32'h3);
    next_cyc();
    bus.req_valid = '0;
    @(negedge clk);
    chk("gap_c5_data", 32'(bus.fifo_data_in), 32'h73);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
